sccb_cfg_sequencer: RTL and testbench

- Table-driven camera configuration sequencer. It walks a register ROM of (sub_addr, data) pairs and issues SCCB writes through the existing SCCB engine's start/done handshake.
- Adds programmable delay entries, an end-of-table marker, re-run on request, and a final product-ID readback (PID 0x0A, VER 0x0B).
- Sits between the APB-side control logic and the SCCB engine. It replaces fixed hard-coded write/read sequences.

---
 rtl/sccb_cfg_pkg.sv | 39 +++
 rtl/sccb_cfg_rom.sv | 28 ++
 rtl/sccb_cfg_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared state encoding, table marker constants and the default OV7670 register
// table for the SCCB configuration sequencer and its ROM.
package sccb_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DELAY,
        ST_NEXT,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_DONE,
        ST_VFY_REQ,
        ST_VFY_WAIT
    } cfg_state_t;

    localparam logic [15:0] END_MARK     = 16'hFFFF;
    localparam logic [7:0]  DLY_SUB      = 8'hFF;
    localparam logic [7:0]  OV7670_WR_ID = 8'h42;
    localparam logic [7:0]  OV7670_RD_ID = 8'h43;
    // The read address differs from the write address only in this bit.
    localparam logic [7:0]  SCCB_RD_BIT  = OV7670_RD_ID ^ OV7670_WR_ID;

    // Default table, regenerated from the camera hex config: {sub_addr, data}.
    function automatic logic [15:0] cfg_rom_entry(input logic [15:0] idx);
        logic [15:0] entry;
        case (idx)
            16'd0:   entry = 16'h1280;
            16'd1:   entry = 16'hFF0A;
            16'd2:   entry = 16'h1204;
            16'd3:   entry = 16'h1101;
            default: entry = END_MARK;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Synchronous configuration ROM with one-cycle read latency, filled from the
// package register table; sits beside the sequencer on its rom_addr/rom_data pair.
module sccb_cfg_rom
    import sccb_cfg_pkg::*;
#(
    parameter int ROM_AW = 6
) (
    input  logic              PCLK,
    input  logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_data
);

    logic [15:0] w_mem [0:(2**ROM_AW)-1];
    logic [15:0] r_data;

    generate
        for (genvar gi = 0; gi < 2**ROM_AW; gi++) begin : g_init
            assign w_mem[gi] = cfg_rom_entry(16'(gi));
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        r_data <= w_mem[rom_addr];
    end

    assign rom_data = r_data;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Table-driven SCCB camera configuration sequencer with delay entries and ID readback.
// Define SCCB_CFG_VERIFY_EN to read back every write and retry on mismatch.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int         ROM_AW    = 6,
    parameter logic [7:0] DEV_ID_W  = OV7670_WR_ID,
    parameter int         DLY_UNIT  = 100,
    parameter logic [7:0] PID_REG   = 8'h0A,
    parameter int         MAX_RETRY = 3
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              mid_pulse,
    input  logic              go,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [ROM_AW-1:0] err_index,
    output logic [15:0]       chip_id,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic              sccb_rw,
    output logic [7:0]        sccb_id_addr,
    output logic [7:0]        sccb_sub_addr,
    output logic [7:0]        sccb_data_in,
    input  logic [7:0]        sccb_data_out,
    input  logic              sccb_done
);

    localparam int         DLY_W    = $clog2(255 * DLY_UNIT + 1);
    localparam int         RETRY_W  = $clog2(MAX_RETRY + 2);
    localparam logic [7:0] DEV_ID_R = DEV_ID_W | SCCB_RD_BIT;

    cfg_state_t        r_state, w_state_next;
    logic              r_busy, w_busy_next;
    logic              r_cfg_done, w_cfg_done_next;
    logic [15:0]       r_chip_id, w_chip_id_next;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_next;
    logic              r_start, w_start_next;
    logic              r_rw, w_rw_next;
    logic [7:0]        r_id, w_id_next;
    logic [7:0]        r_sub, w_sub_next;
    logic [7:0]        r_wdata, w_wdata_next;
    logic [15:0]       r_entry, w_entry_next;
    logic [DLY_W-1:0]  r_dly, w_dly_next;
    logic [RETRY_W-1:0] r_retry, w_retry_next;
    logic              r_id_idx, w_id_idx_next;
    logic [DLY_W-1:0]  w_dly_load;
`ifdef SCCB_CFG_VERIFY_EN
    logic              r_cfg_err, w_cfg_err_next;
    logic [ROM_AW-1:0] r_err_index, w_err_index_next;
`endif

    assign w_dly_load = DLY_W'(32'(rom_data[7:0]) * 32'(DLY_UNIT));

    // Everything advances only on bit-rate steps so the engine sees stable requests.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_cfg_done <= 1'b0;
            r_chip_id  <= '0;
            r_rom_addr <= '0;
            r_start    <= 1'b0;
            r_rw       <= 1'b0;
            r_id       <= '0;
            r_sub      <= '0;
            r_wdata    <= '0;
            r_entry    <= '0;
            r_dly      <= '0;
            r_retry    <= '0;
            r_id_idx   <= 1'b0;
`ifdef SCCB_CFG_VERIFY_EN
            r_cfg_err   <= 1'b0;
            r_err_index <= '0;
`endif
        end else if (mid_pulse) begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_cfg_done <= w_cfg_done_next;
            r_chip_id  <= w_chip_id_next;
            r_rom_addr <= w_rom_addr_next;
            r_start    <= w_start_next;
            r_rw       <= w_rw_next;
            r_id       <= w_id_next;
            r_sub      <= w_sub_next;
            r_wdata    <= w_wdata_next;
            r_entry    <= w_entry_next;
            r_dly      <= w_dly_next;
            r_retry    <= w_retry_next;
            r_id_idx   <= w_id_idx_next;
`ifdef SCCB_CFG_VERIFY_EN
            r_cfg_err   <= w_cfg_err_next;
            r_err_index <= w_err_index_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_busy_next     = r_busy;
        w_cfg_done_next = r_cfg_done;
        w_chip_id_next  = r_chip_id;
        w_rom_addr_next = r_rom_addr;
        w_start_next    = r_start;
        w_rw_next       = r_rw;
        w_id_next       = r_id;
        w_sub_next      = r_sub;
        w_wdata_next    = r_wdata;
        w_entry_next    = r_entry;
        w_dly_next      = r_dly;
        w_retry_next    = r_retry;
        w_id_idx_next   = r_id_idx;
`ifdef SCCB_CFG_VERIFY_EN
        w_cfg_err_next   = r_cfg_err;
        w_err_index_next = r_err_index;
`endif
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_cfg_done_next = 1'b0;
                    w_chip_id_next  = '0;
                    w_rom_addr_next = '0;
                    w_retry_next    = '0;
                    w_busy_next     = 1'b1;
                    w_state_next    = ST_FETCH;
`ifdef SCCB_CFG_VERIFY_EN
                    w_cfg_err_next  = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                w_entry_next = rom_data;
                if (rom_data == END_MARK) begin
                    w_id_idx_next = 1'b0;
                    w_state_next  = ST_ID_REQ;
                end else if (rom_data[15:8] == DLY_SUB) begin
                    w_dly_next   = w_dly_load;
                    w_state_next = (rom_data[7:0] == 8'h00) ? ST_NEXT : ST_DELAY;
                end else begin
                    w_state_next = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                w_id_next    = DEV_ID_W;
                w_rw_next    = 1'b0;
                w_sub_next   = r_entry[15:8];
                w_wdata_next = r_entry[7:0];
                w_start_next = 1'b0;
                w_state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                w_start_next = !sccb_done;
                if (sccb_done) begin
`ifdef SCCB_CFG_VERIFY_EN
                    w_state_next = ST_VFY_REQ;
`else
                    w_state_next = ST_NEXT;
`endif
                end
            end
`ifdef SCCB_CFG_VERIFY_EN
            ST_VFY_REQ: begin
                w_id_next    = DEV_ID_R;
                w_rw_next    = 1'b1;
                w_sub_next   = r_entry[15:8];
                w_start_next = 1'b0;
                w_state_next = ST_VFY_WAIT;
            end
            ST_VFY_WAIT: begin
                w_start_next = !sccb_done;
                if (sccb_done) begin
                    if (sccb_data_out == r_entry[7:0]) begin
                        w_retry_next = '0;
                        w_state_next = ST_NEXT;
                    end else if (r_retry == RETRY_W'(MAX_RETRY)) begin
                        w_cfg_err_next   = 1'b1;
                        w_err_index_next = r_rom_addr;
                        w_busy_next      = 1'b0;
                        w_state_next     = ST_IDLE;
                    end else begin
                        w_retry_next = r_retry + RETRY_W'(1);
                        w_state_next = ST_WR_REQ;
                    end
                end
            end
`endif
            ST_DELAY: begin
                w_dly_next = r_dly - DLY_W'(1);
                if (r_dly <= DLY_W'(1)) begin
                    w_state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // A full table without an end marker still finishes with the ID read.
                if (&r_rom_addr) begin
                    w_id_idx_next = 1'b0;
                    w_state_next  = ST_ID_REQ;
                end else begin
                    w_rom_addr_next = r_rom_addr + ROM_AW'(1);
                    w_state_next    = ST_FETCH;
                end
            end
            ST_ID_REQ: begin
                w_id_next    = DEV_ID_R;
                w_rw_next    = 1'b1;
                w_sub_next   = PID_REG + {7'b0, r_id_idx};
                w_start_next = 1'b0;
                w_state_next = ST_ID_WAIT;
            end
            ST_ID_WAIT: begin
                w_start_next = !sccb_done;
                if (sccb_done) begin
                    if (!r_id_idx) begin
                        w_chip_id_next[15:8] = sccb_data_out;
                        w_id_idx_next        = 1'b1;
                        w_state_next         = ST_ID_REQ;
                    end else begin
                        w_chip_id_next[7:0] = sccb_data_out;
                        w_state_next        = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_cfg_done_next = 1'b1;
                w_busy_next     = 1'b0;
                w_state_next    = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy          = r_busy;
    assign cfg_done      = r_cfg_done;
    assign chip_id       = r_chip_id;
    assign rom_addr      = r_rom_addr;
    assign sccb_start    = r_start;
    assign sccb_rw       = r_rw;
    assign sccb_id_addr  = r_id;
    assign sccb_sub_addr = r_sub;
    assign sccb_data_in  = r_wdata;
`ifdef SCCB_CFG_VERIFY_EN
    assign cfg_err   = r_cfg_err;
    assign err_index = r_err_index;
`else
    assign cfg_err   = 1'b0;
    assign err_index = '0;
`endif

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: ROM and SCCB engine models, linear test steps.
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

    localparam int ROM_AW  = 6;
    localparam int ENG_LAT = 20;
`ifdef SCCB_CFG_VERIFY_EN
    localparam int TXW = 2;
`else
    localparam int TXW = 1;
`endif

    logic              clk = 1'b0;
    logic              PRESETN;
    logic              mid_pulse = 1'b0;
    logic              go;
    logic              busy, cfg_done, cfg_err;
    logic [ROM_AW-1:0] err_index, rom_addr;
    logic [15:0]       chip_id, rom_data;
    logic              sccb_start, sccb_rw, sccb_done;
    logic [7:0]        sccb_id_addr, sccb_sub_addr, sccb_data_in, sccb_data_out;
    logic [ROM_AW-1:0] rom_chk_addr;
    logic [15:0]       rom_chk_data;

    logic [15:0] rom_mem [0:(2**ROM_AW)-1];
    logic [7:0]  regs [0:255];
    logic [31:0] log_tx [0:255];
    logic        eng_busy, eng_rw, stuck_en, wrapped;
    logic [7:0]  eng_id, eng_sub, eng_dat;
    int          eng_cnt;
    int          n_tx = 0, n_wr = 0;
    int          n_chk = 0, n_pass = 0;

    sccb_cfg_sequencer #(.ROM_AW(ROM_AW)) dut (
        .PCLK(clk), .PRESETN(PRESETN), .mid_pulse(mid_pulse), .go(go),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index),
        .chip_id(chip_id), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_start(sccb_start), .sccb_rw(sccb_rw), .sccb_id_addr(sccb_id_addr),
        .sccb_sub_addr(sccb_sub_addr), .sccb_data_in(sccb_data_in),
        .sccb_data_out(sccb_data_out), .sccb_done(sccb_done)
    );

    sccb_cfg_rom #(.ROM_AW(ROM_AW)) u_rom (
        .PCLK(clk), .rom_addr(rom_chk_addr), .rom_data(rom_chk_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // mid_pulse high on every other rising edge; engine answers ENG_LAT steps after start.
    always @(negedge clk) begin
        mid_pulse = ~mid_pulse;
        if (!PRESETN) begin
            eng_busy      = 1'b0;
            sccb_done     = 1'b0;
            sccb_data_out = 8'h00;
            for (int i = 0; i < 256; i++) regs[i] = 8'h00;
            regs[8'h0A] = 8'h76;
            regs[8'h0B] = 8'h73;
        end else if (mid_pulse) begin
            sccb_done = 1'b0;
            if (eng_busy) begin
                eng_cnt++;
                if (eng_cnt == ENG_LAT) begin
                    eng_busy  = 1'b0;
                    sccb_done = 1'b1;
                    if (eng_rw) begin
                        sccb_data_out = (stuck_en && eng_sub == 8'h12) ? 8'h00 : regs[eng_sub];
                        eng_dat       = sccb_data_out;
                    end else begin
                        if (!(stuck_en && eng_sub == 8'h12)) regs[eng_sub] = eng_dat;
                        n_wr++;
                    end
                    if (n_tx < 256) log_tx[n_tx] = {7'b0, eng_rw, eng_id, eng_sub, eng_dat};
                    $display("tx %0d: rw=%0d id=%h sub=%h data=%h", n_tx, eng_rw, eng_id, eng_sub, eng_dat);
                    n_tx++;
                end
            end else if (sccb_start) begin
                eng_busy = 1'b1;
                eng_cnt  = 0;
                eng_rw   = sccb_rw;
                eng_id   = sccb_id_addr;
                eng_sub  = sccb_sub_addr;
                eng_dat  = sccb_data_in;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 2**ROM_AW; i++) rom_mem[i] = 16'hFFFF;
    endtask

    task automatic start_run(input string tag);
        @(posedge clk); #2;
        go = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        go = 1'b0;
        chk(tag, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        logic [ROM_AW-1:0] prev = '0;
        wrapped = 1'b0;
        while (busy !== 1'b0 && t < budget) begin
            @(posedge clk); #2;
            t++;
            if (busy && prev == 6'h3F && rom_addr == 6'h00) wrapped = 1'b1;
            prev = rom_addr;
        end
        chk(tag, 32'(t < budget), 32'd1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int t = 0;
        while (sccb_start !== 1'b1 && t < budget) begin
            @(posedge clk); #2;
            t++;
        end
        chk(tag, 32'(t < budget), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_tx, base_wr, t, steps;
        PRESETN = 1'b0; go = 1'b0; stuck_en = 1'b0; rom_chk_addr = '0;
        rom_clear();
        repeat (4) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        chk("rst_chip_id", 32'(chip_id), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_start", 32'(sccb_start), 32'd0);
        PRESETN = 1'b1;

        // ROM block: one-cycle registered read of the default table
        rom_chk_addr = 6'd1;
        @(posedge clk); #2;
        chk("rom_e1", 32'(rom_chk_data), 32'h0000FF0A);
        rom_chk_addr = 6'd3;
        @(posedge clk); #2;
        chk("rom_e3", 32'(rom_chk_data), 32'h00001101);
        rom_chk_addr = 6'd0;
        #1;
        chk("rom_hold", 32'(rom_chk_data), 32'h00001101);
        @(posedge clk); #2;
        chk("rom_e0", 32'(rom_chk_data), 32'h00001280);

        // Single write then the two ID reads
        rom_clear();
        rom_mem[0] = 16'h1280;
        base_tx = n_tx; base_wr = n_wr;
        start_run("t1_busy_go");
        wait_idle("t1_finish", 4000);
        chk("t1_wr_count", 32'(n_wr - base_wr), 32'd1);
        chk("t1_tx_count", 32'(n_tx - base_tx), 32'(TXW + 2));
        chk("t1_wr", log_tx[base_tx], 32'h00421280);
        chk("t1_pid", log_tx[base_tx + TXW], 32'h01430A76);
        chk("t1_ver", log_tx[base_tx + TXW + 1], 32'h01430B73);
        chk("t1_chip_id", 32'(chip_id), 32'h00007673);
        chk("t1_cfg_done", 32'(cfg_done), 32'd1);
        chk("t1_cfg_err", 32'(cfg_err), 32'd0);

        // Delay entry of 2 units holds off the first write for >= 200 steps
        rom_clear();
        rom_mem[0] = 16'hFF02;
        rom_mem[1] = 16'h1101;
        base_tx = n_tx;
        @(posedge clk); #2;
        go = 1'b1;
        t = 0; steps = 0;
        while (sccb_start !== 1'b1 && t < 1000) begin
            @(posedge clk); #2;
            t++;
            if (mid_pulse) steps++;
            if (t == 4) begin
                go = 1'b0;
                chk("t2_done_cleared", 32'(cfg_done), 32'd0);
                chk("t2_chip_cleared", 32'(chip_id), 32'd0);
            end
        end
        go = 1'b0;
        chk("t2_start_seen", 32'(t < 1000), 32'd1);
        chk("t2_delay_steps", 32'(steps >= 200 && steps <= 215), 32'd1);
        wait_idle("t2_finish", 4000);
        chk("t2_wr", log_tx[base_tx], 32'h00421101);
        chk("t2_tx_count", 32'(n_tx - base_tx), 32'(TXW + 2));
        chk("t2_cfg_done", 32'(cfg_done), 32'd1);

        // Full table with no end marker: 64 writes, no wrap, then ID reads
        for (int i = 0; i < 2**ROM_AW; i++) rom_mem[i] = {8'h40 + 8'(i), 8'(i * 3)};
        base_tx = n_tx; base_wr = n_wr;
        start_run("t3_busy_go");
        wait_idle("t3_finish", 20000);
        chk("t3_wr_count", 32'(n_wr - base_wr), 32'd64);
        chk("t3_last_wr", log_tx[base_tx + 63 * TXW], 32'h00427FBD);
        chk("t3_pid", log_tx[base_tx + 64 * TXW], 32'h01430A76);
        chk("t3_no_wrap", 32'(wrapped), 32'd0);
        chk("t3_rom_addr_end", 32'(rom_addr), 32'h3F);
        chk("t3_chip_id", 32'(chip_id), 32'h00007673);

        // Reset while waiting on the engine
        rom_clear();
        rom_mem[0] = 16'h1280;
        start_run("t4_busy_go");
        wait_start("t4_start_seen", 400);
        #1;
        PRESETN = 1'b0;
        #1;
        chk("t4_rst_start", 32'(sccb_start), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_addr", 32'(rom_addr), 32'd0);
        chk("t4_rst_done", 32'(cfg_done), 32'd0);
        @(posedge clk); #2;
        PRESETN = 1'b1;
        base_tx = n_tx; base_wr = n_wr;
        start_run("t4_busy_restart");
        wait_idle("t4_finish", 4000);
        chk("t4_wr_count", 32'(n_wr - base_wr), 32'd1);
        chk("t4_wr", log_tx[base_tx], 32'h00421280);
        chk("t4_chip_id", 32'(chip_id), 32'h00007673);

        // go while busy is ignored
        base_tx = n_tx; base_wr = n_wr;
        start_run("t5_busy_go");
        wait_start("t5_start_seen", 400);
        go = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        go = 1'b0;
        wait_idle("t5_finish", 4000);
        repeat (20) @(posedge clk);
        #2;
        chk("t5_wr_count", 32'(n_wr - base_wr), 32'd1);
        chk("t5_tx_count", 32'(n_tx - base_tx), 32'(TXW + 2));
        chk("t5_stay_idle", 32'(busy), 32'd0);

`ifdef SCCB_CFG_VERIFY_EN
        // Register 0x12 never takes the write: 1 + MAX_RETRY writes then error
        stuck_en = 1'b1;
        base_tx = n_tx; base_wr = n_wr;
        start_run("t6_busy_go");
        wait_idle("t6_finish", 6000);
        chk("t6_wr_count", 32'(n_wr - base_wr), 32'd4);
        chk("t6_tx_count", 32'(n_tx - base_tx), 32'd8);
        chk("t6_cfg_err", 32'(cfg_err), 32'd1);
        chk("t6_err_index", 32'(err_index), 32'd0);
        chk("t6_cfg_done", 32'(cfg_done), 32'd0);
        chk("t6_chip_id", 32'(chip_id), 32'd0);
        stuck_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
